// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM peripheral and its SPI register front end.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // Register map shared with the SPI peripheral
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    OUT_LOW  = 2'd0,
    OUT_HIGH = 2'd1,
    OUT_PWM  = 2'd2
  } out_mode_e;

  function automatic logic out_bit(input logic en_out, input logic en_pwm, input logic lvl);
    out_mode_e mode;
    logic      b;
    mode = !en_out ? OUT_LOW : (en_pwm ? OUT_PWM : OUT_HIGH);
    case (mode)
      OUT_LOW:  b = 1'b0;
      OUT_HIGH: b = 1'b1;
      OUT_PWM:  b = lvl;
      default:  b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler, 8-bit period counter and period-wrap pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap,
  output logic                 period_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;

  // Tick and wrap decode from the current counter state
  always_comb begin
    tick_s = (div_cnt_r == DIV_MAX);
    wrap   = tick_s && (pwm_cnt == {PWM_CNT_W{1'b1}});
  end

  // Prescaler, period counter and registered period-start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r    <= {DIV_W{1'b0}};
      pwm_cnt      <= {PWM_CNT_W{1'b0}};
      period_start <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        pwm_cnt   <= pwm_cnt + 1'b1;
      end else begin
        div_cnt_r <= div_cnt_r + 1'b1;
        pwm_cnt   <= pwm_cnt;
      end
      period_start <= wrap;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral top: duty selection, PWM compare and the 16-bit registered output mux.
// Define PWM_DUTY_SHADOW_EN to defer duty updates to the next period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [PWM_CNT_W-1:0] pwm_cnt_s;
  logic                 wrap_s;
  logic [7:0]           duty_eff_s;
  logic                 pwm_lvl_s;
  logic [15:0]          en_out_s;
  logic [15:0]          en_pwm_s;
  logic [15:0]          out_nxt_s;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt_s),
    .wrap         (wrap_s),
    .period_start (period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow_r;

  // Capture the duty value on the wrap edge so a period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_r <= 8'h00;
    end else if (wrap_s) begin
      duty_shadow_r <= pwm_duty_cycle;
    end else begin
      duty_shadow_r <= duty_shadow_r;
    end
  end

  assign duty_eff_s = duty_shadow_r;
`else
  logic unused_wrap_s;
  assign unused_wrap_s = wrap_s;
  assign duty_eff_s    = pwm_duty_cycle;
`endif

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Full-scale duty is forced high so the 255 count never drops out
  always_comb begin
    if (duty_eff_s == DUTY_FULL) begin
      pwm_lvl_s = 1'b1;
    end else begin
      pwm_lvl_s = (pwm_cnt_s < duty_eff_s);
    end
  end

  // Per-bit mode mux
  always_comb begin
    out_nxt_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      out_nxt_s[i] = out_bit(en_out_s[i], en_pwm_s[i], pwm_lvl_s);
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 16'h0000;
    end else begin
      out <= out_nxt_s;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five configuration registers written by the SPI peripheral and drives the 16 user outputs. Each output bit is forced low, forced high, or driven by a shared 8-bit PWM waveform. A prescaler and a period counter form the PWM timebase. Duty-cycle updates can be held back until a period boundary so that no PWM period is ever truncated.

## Interface
- `CLK_DIV`, default 13: clk cycles per PWM tick. Legal range ≥ 1. At 10 MHz this gives 10e6/(256·13) ≈ 3004 Hz.
- `clk`  in  1: system clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `en_reg_out_7_0`  in  8: output enable, bits 7:0.
- `en_reg_out_15_8`  in  8: output enable, bits 15:8.
- `en_reg_pwm_7_0`  in  8: PWM mode select, bits 7:0.
- `en_reg_pwm_15_8`  in  8: PWM mode select, bits 15:8.
- `pwm_duty_cycle`  in  8: shared duty value, 0..255.
- `out`  out  16: user outputs. Registered.
- `period_start`  out  1: one-cycle pulse at every PWM period wrap. Registered.

## Operation
- **Prescaler `div_cnt`**
  - Counts 0..CLK_DIV-1 and wraps.
  - `tick` is high when `div_cnt == CLK_DIV-1`.
  - With CLK_DIV=1, `tick` is high every cycle.
- **Period counter `pwm_cnt`** (8 bit)
  - Increments on `tick` and wraps 255→0 naturally.
  - Wrap event = `tick && pwm_cnt == 255`.
- **On the edge where the wrap event is true:**
  - `period_start` is set to 1; it returns to 0 on the next edge.
  - `duty_shadow` loads the `pwm_duty_cycle` value present at that edge. This includes a duty value that changes in the same cycle.
- **Effective duty `duty_eff`:** `duty_shadow`, or `pwm_duty_cycle` directly (see Configuration).
- **PWM level `pwm_lvl`:**
  - 1 if `duty_eff == 8'hFF`; otherwise `pwm_cnt < duty_eff` (unsigned 8-bit compare).
  - Duty 0 gives constant 0. Duty 255 gives constant 1, with no one-tick dropout.
- **Per bit i, registered each clk:**
  - `en_out[i] == 0` → `out[i] = 0`.
  - `en_out[i] == 1`, `en_pwm[i] == 0` → `out[i] = 1`.
  - Both set → `out[i] = pwm_lvl`.
  - `en_pwm[i]` is ignored when `en_out[i] == 0`.
- **Reset values:** `div_cnt = 0`, `pwm_cnt = 0`, `duty_shadow = 8'h00`, `out = 16'h0000`, `period_start = 0`.
- **Reset mid-operation:** all of the above take their reset values on the next clk edge, regardless of state. The period restarts from `pwm_cnt = 0`.
- **No wrap at reset release:** `period_start` is not pulsed on reset release.
  - With shadowing enabled, the first period after reset uses duty 0.
  - PWM-mode bits therefore stay low until the first `period_start`.

## Timing
- **Enable change:** an input-register change appears on `out` one clk after the edge at which it is sampled.
- **PWM state change:** `out` reflects `pwm_cnt`/`duty_eff` with a 1-cycle lag.
- **Period length:** 256·CLK_DIV clk cycles.
- **High time:** duty·CLK_DIV cycles per period (0 for duty 0; the full period for duty 255).
- **Period start:**
  - The first `period_start` rises 256·CLK_DIV edges after the first edge with `rst` low.
  - Subsequent pulses are spaced exactly 256·CLK_DIV cycles apart.
- **PWM high phase:** begins one cycle after `period_start` rises, i.e. at the first registered cycle of `pwm_cnt == 0`.
- **No handshake:** inputs are treated as quasi-static registers in the same clk domain and need no synchronisation.

## Configuration
- **`PWM_DUTY_SHADOW_EN` defined:**
  - `duty_eff = duty_shadow`.
  - A duty write takes effect only at the next period wrap.
  - Periods are never truncated or glitched.
- **`PWM_DUTY_SHADOW_EN` undefined:**
  - The `duty_shadow` register is removed and `duty_eff = pwm_duty_cycle`.
  - A duty change affects `out` one clk after it is sampled, possibly mid-period.
  - `period_start` behaviour is unchanged.

## Structure
- **Package `pwm_pkg`:**
  - `PWM_CNT_W = 8`.
  - `DUTY_FULL = 8'hFF`.
  - Register address constants `ADDR_EN_OUT_7_0 = 7'h00` through `ADDR_PWM_DUTY = 7'h04`, shared with the SPI peripheral.
- **Sub-module `pwm_timebase`:**
  - Contains the prescaler, `pwm_cnt` and wrap/`period_start` generation.
  - Ports: clk, rst, `pwm_cnt`, `wrap`, `period_start`.
- **Top level:** holds `duty_shadow`, the compare and the 16-bit output mux.

## Test plan
1. **Reset:** hold `rst` 2 cycles with all inputs 8'hFF → `out = 16'h0000`, `period_start = 0` throughout reset and one cycle after.
2. **Static high:** `en_reg_out_7_0 = 8'h01`, `en_reg_out_15_8 = 8'h80`, PWM regs 0 → `out = 16'h8001` one cycle later; clearing the enables → `out = 16'h0000` one cycle later.
3. **50% PWM:** CLK_DIV=13, `en_out`/`en_pwm` bit 0 set, duty 8'h80, shadow on → after the first `period_start`, `out[0]` high 1664 cycles, low 1664, period 3328, repeating.
4. **Duty boundaries:**
   - Duty 8'h00 → `out[0]` constant 0.
   - Duty 8'hFF → `out[0]` constant 1 across ≥ 2 full periods, including wrap cycles.
   - Duty 8'h01 → high exactly 13 cycles per period.
5. **Mid-period duty change:** 8'h40→8'hC0 at half period.
   - Shadow on: current period high time stays 832; the next period's is 2496.
   - Macro off: `out[0]` rises one cycle after the change.
6. **Mid-period reset:** assert `rst` at `pwm_cnt = 100` → `out = 0` next edge; after release, the next `period_start` arrives at exactly 3328 cycles.
